mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
Multi-cycle successor to the single-cycle MIPS core. Instructions and data share one external word memory, reached through a req/ready handshake, so the memory may insert wait states. Width of the memory address, width of the input port and the I/O base address are parameters. Adds jumps (j, jal, jr), an internal memory-mapped PortIn/PortOut, and an illegal-opcode trap.

Parameters:
ADDR_WIDTH, 12, byte-address bits driven on mem_addr (word aligned, bits [1:0] always 0)
PORT_WIDTH, 8, width of PortIn; zero-extended to 32 bits on read
RESET_PC, 32'h0000_0000, PC value loaded on reset
IO_BASE, 32'h1001_0024, PortIn read address; IO_BASE+4 is the PortOut register

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
PortIn  in  PORT_WIDTH  external input, read by lw IO_BASE
PortOut  out  32  register written by sw IO_BASE+4
ALUResultOut  out  32  registered ALU result of the last EXEC cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, qualified by mem_req
mem_addr  out  ADDR_WIDTH  word-aligned byte address
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  access completes on a cycle with mem_req=1 and mem_ready=1
trap  out  1  high while in TRAP state

Behaviour:
- Reset (reset=0 at posedge), regardless of current state:
  - PC=RESET_PC, state=FETCH.
  - All 32 GPRs=0; PortOut=0; ALUResultOut=0.
  - mem_req=0, mem_we=0, trap=0.
  - An in-flight handshake is abandoned; the memory must tolerate a dropped request.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ready: IR<=mem_rdata, PC<=PC+4, go to DECODE. Otherwise hold.
- DECODE:
  - A<=GPR[rs], B<=GPR[rt]; imm sign-extended (zero-extended for ori).
  - Unknown opcode or funct: go to TRAP.
- EXEC:
  - ALU: add/addi, sub, and, or/ori, slt (signed), sll/srl by shamt, lui (imm<<16). Arithmetic wraps modulo 2^32; no overflow exception.
  - beq/bne: if taken, PC<=PC+(imm<<2) (PC already +4). Go to FETCH.
  - j: PC<={PC[31:28],IR[25:0],2'b00}. Go to FETCH.
  - jal: same target as j, and GPR[31]<=PC (old PC+4). Go to FETCH.
  - jr: PC<=A. Go to FETCH.
  - lw/sw: go to MEM. All others: go to WB.
- MEM:
  - Effective address EA=A+imm.
  - EA==IO_BASE (lw): load data = zero-extended PortIn, 1 cycle, no bus access.
  - EA==IO_BASE+4 (sw): PortOut<=B, 1 cycle, no bus access.
  - Otherwise: mem_req=1, mem_we=sw, mem_addr=EA[ADDR_WIDTH-1:2]<<2, mem_wdata=B. Wait for mem_ready. lw latches mem_rdata and goes to WB; sw goes to FETCH.
- WB:
  - Destination: rd for R-type, rt for I-type.
  - Writes to register 0 are discarded; reads of register 0 always return 0.
- TRAP: trap=1, mem_req=0, state holds until reset.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_req drops in the cycle after completion unless the next state also requests.
  - mem_ready while mem_req=0 is ignored.
- Cycle counts with zero wait states:
  - R-type/I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw, branch, jump: 3 cycles (sw 4 via MEM).
  - Each wait cycle adds 1 cycle.

Optional Feature:
CORE_PERF_COUNTERS_EN
- Defined: two 32-bit counters, both wrapping at 2^32 and cleared by reset.
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on each instruction completion (transition into FETCH from EXEC, MEM or WB).
  - lw IO_BASE+8 returns cycle_cnt; lw IO_BASE+12 returns instret_cnt. Neither address uses the bus.
- Undefined: no counters; those addresses are ordinary bus accesses.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release → mem_req=1, mem_addr=0 on the first cycle; PortOut=0; trap=0.
- addi $t0,$0,5; addi $t1,$0,-3; add $t2,$t0,$t1; zero wait states → $t2=2, ALUResultOut=2, 12 cycles total.
- I/O: PortIn=8'hA5; lw $t0,0($s0) with $s0=IO_BASE; sw $t0,4($s0) → PortOut=32'h0000_00A5; mem_req never high during MEM.
- Wait states: mem_ready delayed 3 cycles on each access; sw $t0 (=32'hDEAD_BEEF) to 0x40 → mem_addr, mem_wdata and mem_we stay stable for 4 cycles, then one write to 0x40.
- Control flow:
  - bne $0,$0,+4 is not taken → next fetch at PC+4.
  - jal 0x100 from PC=0x20 → $31=0x24, next fetch at 0x100.
  - jr $31 → next fetch at 0x24.
- Trap and reset: opcode 6'h3F → trap=1 and mem_req=0 held for 10 cycles; reset=0 → trap=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core. Instructions and data share one req/ready word memory.
// Define CORE_PERF_COUNTERS_EN to map cycle/instret counters at IO_BASE+8/+12.
module mips_multicycle_core #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          PORT_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IO_BASE    = 32'h1001_0024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PORT_WIDTH-1:0] PortIn,
    output logic [31:0]           PortOut,
    output logic [31:0]           ALUResultOut,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  trap
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q;
    logic [31:0] a_q, b_q, imm_q;
    logic [31:0] alu_q, mdr_q, port_q;
    logic [31:0] rf_q [32];

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh, wb_dst;

    assign op = ir_q[31:26];
    assign rs = ir_q[25:21];
    assign rt = ir_q[20:16];
    assign rd = ir_q[15:11];
    assign sh = ir_q[10:6];
    assign fn = ir_q[5:0];

    logic is_r, is_lw, is_sw, is_beq, is_bne;
    logic is_j, is_jal, is_jr, is_ctrl, legal;

    assign is_r    = (op == OP_R);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);
    assign is_jr   = is_r && (fn == F_JR);
    assign is_ctrl = is_beq | is_bne | is_j | is_jal | is_jr;
    assign wb_dst  = is_r ? rd : rt;

    always_comb begin
        legal = 1'b0;
        unique case (op)
            OP_R: legal = fn inside {F_SLL, F_SRL, F_JR, F_ADD,
                                     F_SUB, F_AND, F_OR, F_SLT};
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    logic [31:0] alu_res;

    // lw/sw/addi fall through to A+imm, which is also the effective address
    always_comb begin
        alu_res = a_q + imm_q;
        case (op)
            OP_R: begin
                case (fn)
                    F_SUB:   alu_res = a_q - b_q;
                    F_AND:   alu_res = a_q & b_q;
                    F_OR:    alu_res = a_q | b_q;
                    F_SLT:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
                    F_SLL:   alu_res = b_q << sh;
                    F_SRL:   alu_res = b_q >> sh;
                    default: alu_res = a_q + b_q;
                endcase
            end
            OP_ORI:         alu_res = a_q | imm_q;
            OP_LUI:         alu_res = {imm_q[15:0], 16'h0000};
            OP_BEQ, OP_BNE: alu_res = a_q - b_q;
            default:        ;
        endcase
    end

`ifdef CORE_PERF_COUNTERS_EN
    logic [31:0] cycle_q, instret_q;
    logic        retire;

    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_EXEC || state_q == S_MEM ||
                     state_q == S_WB);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end
`endif

    logic        io_in, io_out, bus_mem;
    logic [31:0] io_rdata;

    always_comb begin
        io_in    = is_lw && (alu_q == IO_BASE);
        io_rdata = 32'(PortIn);
`ifdef CORE_PERF_COUNTERS_EN
        if (is_lw && alu_q == IO_BASE + 32'd8) begin
            io_in    = 1'b1;
            io_rdata = cycle_q;
        end
        if (is_lw && alu_q == IO_BASE + 32'd12) begin
            io_in    = 1'b1;
            io_rdata = instret_q;
        end
`endif
    end

    assign io_out  = is_sw && (alu_q == IO_BASE + 32'd4);
    assign bus_mem = (state_q == S_MEM) && !io_in && !io_out;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                    pc_d    = pc_q + 32'd4;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_ctrl)
                    state_d = S_FETCH;
                else if (is_lw || is_sw)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
                if ((is_beq && a_q == b_q) || (is_bne && a_q != b_q))
                    pc_d = pc_q + {imm_q[29:0], 2'b00};
                if (is_j || is_jal)
                    pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                if (is_jr)
                    pc_d = a_q;
            end
            S_MEM: begin
                if (!bus_mem || mem_ready)
                    state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
    end

    // Register 0 is never written, so its reset value keeps reads at zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            port_q  <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) ir_q <= mem_rdata;
                end
                S_DECODE: begin
                    a_q   <= rf_q[rs];
                    b_q   <= rf_q[rt];
                    imm_q <= (op == OP_ORI) ? {16'h0000, ir_q[15:0]}
                                            : {{16{ir_q[15]}}, ir_q[15:0]};
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    if (is_jal) rf_q[31] <= pc_q;
                end
                S_MEM: begin
                    if (io_out) port_q <= b_q;
                    if (io_in)
                        mdr_q <= io_rdata;
                    else if (mem_ready)
                        mdr_q <= mem_rdata;
                end
                S_WB: begin
                    if (wb_dst != 5'd0)
                        rf_q[wb_dst] <= is_lw ? mdr_q : alu_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = reset && (state_q == S_FETCH || bus_mem);
    assign mem_we    = reset && bus_mem && is_sw;
    assign mem_addr  = (state_q == S_MEM) ? {alu_q[ADDR_WIDTH-1:2], 2'b00}
                                          : {pc_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata = b_q;
    assign trap      = (state_q == S_TRAP);
    assign PortOut   = port_q;
    assign ALUResultOut = alu_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed and random programs checked against an instruction-level model
// of the core running on a wait-state word memory.
`timescale 1ns/1ps
module tb_mips_multicycle_core;

    localparam logic [31:0] IO_BASE = 32'h1001_0024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  PortIn = 8'h00;
    logic [31:0] PortOut, ALUResultOut, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_req, mem_we, trap;
    logic        mem_ready = 1'b0;
    logic [11:0] mem_addr;

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .PortIn(PortIn), .PortOut(PortOut),
        .ALUResultOut(ALUResultOut), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .trap(trap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0] img  [1024];
    logic [31:0] tmem [1024];
    logic [31:0] mm   [1024];
    int          waits [4096];

    logic [11:0] act_addr[$];
    bit          act_we[$];
    logic [31:0] act_wd[$];
    logic [11:0] exp_addr[$];
    bit          exp_we[$];
    logic [31:0] exp_wd[$];

    int          tidx, hs_viol, we40_cyc, rem;
    bit          busy;
    logic [11:0] h_addr;
    logic        h_we;
    logic [31:0] h_wd;

    // Memory: answers 1ns after the falling edge, completes on the next rise
    always @(negedge clk) begin
        #1;
        if (mem_req) begin
            if (!busy) begin
                busy   = 1'b1;
                rem    = waits[tidx % 4096];
                h_addr = mem_addr;
                h_we   = mem_we;
                h_wd   = mem_wdata;
            end else if (mem_addr !== h_addr || mem_we !== h_we ||
                         mem_wdata !== h_wd) begin
                hs_viol++;
            end
            if (mem_we && mem_addr == 12'h040) we40_cyc++;
            if (rem == 0) begin
                mem_ready = 1'b1;
                mem_rdata = tmem[mem_addr[11:2]];
                act_addr.push_back(mem_addr);
                act_we.push_back(mem_we);
                act_wd.push_back(mem_wdata);
                if (mem_we) tmem[mem_addr[11:2]] = mem_wdata;
                busy = 1'b0;
                tidx++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                rem--;
            end
        end else begin
            busy      = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int op, int tgt);
        return {6'(op), 26'(tgt >> 2)};
    endfunction

    function automatic logic [11:0] act_at(int i);
        if (i < act_addr.size()) return act_addr[i];
        return 12'hFFF;
    endfunction

    logic [31:0] m_rf [32];
    logic [31:0] m_port, m_last;
    int          m_cyc;

    task automatic m_bus(input logic [11:0] a, input bit we, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_we.push_back(we);
        exp_wd.push_back(d);
        m_cyc += waits[(exp_addr.size() - 1) % 4096];
    endtask

    task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endtask

    // Executes whole instructions; cycle cost per class plus bus wait states
    task automatic model_run();
        logic [31:0] pc, ir, a, b, simm, zimm, ea;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        bit          stop;
        int          n;
        for (int i = 0; i < 1024; i++) mm[i] = img[i];
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        exp_addr.delete(); exp_we.delete(); exp_wd.delete();
        m_port = '0; m_last = '0; m_cyc = 0;
        pc = 32'h0; stop = 1'b0; n = 0;
        while (!stop && n < 5000) begin
            n++;
            ir = mm[pc[11:2]];
            m_bus(pc[11:0], 1'b0, 32'h0);
            pc = pc + 32'd4;
            rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            sh = ir[10:6];  fn = ir[5:0];
            a = m_rf[rs]; b = m_rf[rt];
            simm = {{16{ir[15]}}, ir[15:0]};
            zimm = {16'h0, ir[15:0]};
            case (ir[31:26])
                6'h00: begin
                    m_cyc += 4;
                    case (fn)
                        6'h20: m_wr(rd, a + b);
                        6'h22: m_wr(rd, a - b);
                        6'h24: m_wr(rd, a & b);
                        6'h25: m_wr(rd, a | b);
                        6'h2A: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                        6'h00: m_wr(rd, b << sh);
                        6'h02: m_wr(rd, b >> sh);
                        6'h08: begin pc = a; m_cyc -= 1; end
                        default: begin stop = 1'b1; m_cyc -= 4; end
                    endcase
                end
                6'h08: begin m_wr(rt, a + simm); m_cyc += 4; end
                6'h0D: begin m_wr(rt, a | zimm); m_cyc += 4; end
                6'h0F: begin m_wr(rt, {ir[15:0], 16'h0}); m_cyc += 4; end
                6'h04: begin if (a == b) pc = pc + (simm << 2); m_cyc += 3; end
                6'h05: begin if (a != b) pc = pc + (simm << 2); m_cyc += 3; end
                6'h02: begin pc = {pc[31:28], ir[25:0], 2'b00}; m_cyc += 3; end
                6'h03: begin
                    m_wr(5'd31, pc);
                    pc = {pc[31:28], ir[25:0], 2'b00};
                    m_cyc += 3;
                end
                6'h23: begin
                    ea = a + simm; m_last = ea;
                    if (ea == IO_BASE) m_wr(rt, {24'h0, PortIn});
                    else begin
                        m_bus(ea[11:0] & 12'hFFC, 1'b0, 32'h0);
                        m_wr(rt, mm[ea[11:2]]);
                    end
                    m_cyc += 5;
                end
                6'h2B: begin
                    ea = a + simm; m_last = ea;
                    if (ea == IO_BASE + 32'd4) m_port = b;
                    else begin
                        m_bus(ea[11:0] & 12'hFFC, 1'b1, b);
                        mm[ea[11:2]] = b;
                    end
                    m_cyc += 4;
                end
                default: stop = 1'b1;
            endcase
            if (stop) m_cyc += 2;
            else if (ir[31:26] inside {6'h08, 6'h0D, 6'h0F} ||
                     (ir[31:26] == 6'h00 && fn != 6'h08))
                m_last = (rd == 0 && ir[31:26] == 6'h00) ? m_last : m_last;
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
    endtask

    // Stores every register to 0xA00+4r, then an illegal opcode ends the run
    task automatic put_dump(input int base);
        for (int r = 0; r < 32; r++)
            img[base + r] = enc_i(6'h2B, 0, r, 12'hA00 + 4 * r);
        img[base + 32] = 32'hFC00_0000;
    endtask

    task automatic gen_random();
        int k, rs, rt, rd, n;
        n = 40;
        clear_img();
        for (int i = 512; i < 576; i++) img[i] = $urandom;
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(0, 13);
            rs = $urandom_range(0, 15);
            rt = $urandom_range(0, 15);
            rd = $urandom_range(0, 15);
            if (k >= 12 && i == n - 1) k = 0;
            case (k)
                0:  img[i] = enc_i(6'h08, rs, rt, $urandom);
                1:  img[i] = enc_i(6'h0D, rs, rt, $urandom);
                2:  img[i] = enc_i(6'h0F, 0, rt, $urandom);
                3:  img[i] = enc_r(rs, rt, rd, 0, 6'h20);
                4:  img[i] = enc_r(rs, rt, rd, 0, 6'h22);
                5:  img[i] = enc_r(rs, rt, rd, 0, 6'h24);
                6:  img[i] = enc_r(rs, rt, rd, 0, 6'h25);
                7:  img[i] = enc_r(rs, rt, rd, 0, 6'h2A);
                8:  img[i] = enc_r(0, rt, rd, $urandom_range(0, 31), 6'h00);
                9:  img[i] = enc_r(0, rt, rd, $urandom_range(0, 31), 6'h02);
                10: img[i] = enc_i(6'h23, 0, rt, 12'h800 + 4 * $urandom_range(0, 63));
                11: img[i] = enc_i(6'h2B, 0, rt, 12'h800 + 4 * $urandom_range(0, 63));
                12: img[i] = enc_i(6'h04, rs, rt, 1);
                default: img[i] = enc_i(6'h05, rs, rt, 1);
            endcase
        end
        put_dump(n);
    endtask

    task automatic run_prog(input int wmax, input int wfix, input bit chk12);
        int cyc, bad;
        for (int k = 0; k < 4096; k++)
            waits[k] = (wfix >= 0) ? wfix : $urandom_range(0, wmax);
        model_run();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_alu", ALUResultOut, 32'h0);
        for (int i = 0; i < 1024; i++) tmem[i] = img[i];
        act_addr.delete(); act_we.delete(); act_wd.delete();
        tidx = 0; hs_viol = 0; we40_cyc = 0; busy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("boot_req", {31'b0, mem_req}, 32'h1);
        chk("boot_addr", {20'b0, mem_addr}, 32'h0);
        cyc = 0;
        while (trap !== 1'b1 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            #2;
            if (chk12 && cyc == 12) begin
                chk("alu_at12", ALUResultOut, 32'h2);
                chk("fetch_at12", {20'b0, mem_addr}, 32'hC);
            end
        end
        chk("cycles", cyc, m_cyc);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            #2;
            chk("trap_hold", {30'b0, trap, mem_req}, 32'h2);
        end
        chk("portout", PortOut, m_port);
        chk("alu_out", ALUResultOut, m_last);
        chk("hs_stable", hs_viol, 0);
        chk("txn_count", act_addr.size(), exp_addr.size());
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            bad = failures;
            chk("txn_addr", {20'b0, act_addr[i]}, {20'b0, exp_addr[i]});
            chk("txn_we", {31'b0, act_we[i]}, {31'b0, exp_we[i]});
            if (exp_we[i]) chk("txn_wdata", act_wd[i], exp_wd[i]);
            if (failures != bad) break;
        end
        for (int i = 512; i < 704; i++) chk("dmem", tmem[i], mm[i]);
    endtask

    int n40;

    initial begin
        // ALU sequence, then I/O through PortIn/PortOut
        clear_img();
        PortIn = 8'hA5;
        img[0] = enc_i(6'h08, 0, 8, 5);
        img[1] = enc_i(6'h08, 0, 9, -3);
        img[2] = enc_r(8, 9, 10, 0, 6'h20);
        img[3] = enc_i(6'h0F, 0, 16, 16'h1001);
        img[4] = enc_i(6'h0D, 16, 16, 16'h0024);
        img[5] = enc_i(6'h2B, 16, 10, 4);
        img[6] = enc_i(6'h23, 16, 8, 0);
        img[7] = enc_i(6'h2B, 16, 8, 4);
        put_dump(8);
        run_prog(0, 0, 1'b1);
        chk("portout_a5", PortOut, 32'hA5);
        chk("t2_dump", tmem[(12'hA00 + 4 * 10) >> 2], 32'h2);

        // Store with three wait states per access
        clear_img();
        img[0]   = enc_j(6'h02, 12'h200);
        img[128] = enc_i(6'h0F, 0, 8, 16'hDEAD);
        img[129] = enc_i(6'h0D, 8, 8, 16'hBEEF);
        img[130] = enc_i(6'h2B, 0, 8, 12'h040);
        put_dump(131);
        run_prog(0, 3, 1'b0);
        n40 = 0;
        for (int i = 0; i < act_addr.size(); i++)
            if (act_we[i] && act_addr[i] == 12'h040) n40++;
        chk("sw40_stable", we40_cyc, 4);
        chk("sw40_writes", n40, 1);
        chk("sw40_data", tmem[16], 32'hDEAD_BEEF);

        // Branch not taken, jal, jr
        clear_img();
        img[0] = enc_i(6'h05, 0, 0, 1);
        for (int i = 1; i < 8; i++) img[i] = enc_i(6'h08, 9, 9, 1);
        img[8]  = enc_j(6'h03, 12'h100);
        img[9]  = enc_j(6'h02, 12'h300);
        img[64] = enc_i(6'h08, 0, 10, 7);
        img[65] = enc_r(31, 0, 0, 0, 6'h08);
        put_dump(192);
        run_prog(1, -1, 1'b0);
        chk("bne_not_taken", {20'b0, act_at(1)}, 32'h004);
        chk("jal_target", {20'b0, act_at(9)}, 32'h100);
        chk("jr_target", {20'b0, act_at(11)}, 32'h024);
        chk("ra_dump", tmem[(12'hA00 + 4 * 31) >> 2], 32'h24);

        for (int r = 0; r < 4; r++) begin
            PortIn = 8'($urandom);
            gen_random();
            run_prog((r == 0) ? 0 : 2, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
